// File: rtl/br_lite_ni_pkg.sv
// Shared BrLite flit/service types plus the NI's TX/RX state encodings.
// Flit = {source, target, service, payload, id}; id wraps at 2^BR_ID_W.
package br_lite_ni_pkg;

  localparam int BR_ADDR_W    = 16;
  localparam int BR_PAYLOAD_W = 32;
  localparam int BR_ID_W      = 8;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'd0,
    BR_SVC_TGT   = 2'd1,
    BR_SVC_CLEAR = 2'd2
  } br_service_t;

  typedef struct packed {
    logic [BR_ADDR_W-1:0]    src;
    logic [BR_ADDR_W-1:0]    tgt;
    br_service_t             service;
    logic [BR_PAYLOAD_W-1:0] payload;
    logic [BR_ID_W-1:0]      id;
  } br_data_t;

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_REQ      = 2'd1,
    TX_WAIT_LOW = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

  // Only broadcast and targeted requests may be injected by the PE.
  function automatic logic br_svc_injectable(input br_service_t svc);
    return (svc == BR_SVC_ALL) || (svc == BR_SVC_TGT);
  endfunction

endpackage

// File: rtl/br_lite_ni_fifo.sv
// First-word-fall-through flit FIFO, 1-cycle write-to-read latency.
// Full/empty come from registered pointers only; push when full and pop when empty are ignored.
module br_lite_ni_fifo
  import br_lite_ni_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push,
  input  br_data_t push_dat,
  input  logic     pop,
  output br_data_t pop_dat,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  br_data_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes a full wrap from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/br_lite_ni.sv
// BrLite local-port NI: PE valid/ready <-> router 4-phase req/ack; req rises 1 cycle after accept.
// TX stalls on router busy; RX withholds ack while its FIFO is full. BR_LITE_NI_STATS_EN adds tx/rx counters.
module br_lite_ni
  import br_lite_ni_pkg::*;
#(
  parameter logic [BR_ADDR_W-1:0] ADDRESS  = 16'h0000,
  parameter int                   RX_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    tx_valid_i,
  output logic                    tx_ready_o,
  input  logic [BR_ADDR_W-1:0]    tx_target_i,
  input  br_service_t             tx_service_i,
  input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
  output logic                    tx_err_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output br_data_t                rx_data_o,
  output br_data_t                rtr_flit_o,
  output logic                    rtr_req_o,
  input  logic                    rtr_ack_i,
  input  logic                    rtr_busy_i,
  input  br_data_t                rtr_flit_i,
  input  logic                    rtr_req_i,
  output logic                    rtr_ack_o
`ifdef BR_LITE_NI_STATS_EN
  ,
  output logic [31:0]             tx_cnt_o,
  output logic [31:0]             rx_cnt_o
`endif
);

  tx_state_t          tx_state;
  rx_state_t          rx_state;
  logic [BR_ID_W-1:0] id_cnt;
  logic               tx_fire;
  logic               tx_done;
  logic               rx_push;
  logic               rx_pop;
  logic               fifo_full;
  logic               fifo_empty;

  // Ready is forced low while reset is asserted, not just once the FSM settles.
  assign tx_ready_o = rst_ni && (tx_state == TX_IDLE) && !rtr_busy_i;
  assign tx_fire    = tx_valid_i && tx_ready_o;
  assign tx_done    = (tx_state == TX_REQ) && rtr_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state   <= TX_IDLE;
      id_cnt     <= '0;
      rtr_req_o  <= 1'b0;
      rtr_flit_o <= '0;
      tx_err_o   <= 1'b0;
    end else begin
      tx_err_o <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_fire) begin
            if (br_svc_injectable(tx_service_i)) begin
              rtr_flit_o <= '{src:     ADDRESS,
                              tgt:     tx_target_i,
                              service: tx_service_i,
                              payload: tx_payload_i,
                              id:      id_cnt};
              id_cnt     <= id_cnt + BR_ID_W'(1);
              rtr_req_o  <= 1'b1;
              tx_state   <= TX_REQ;
            end else begin
              tx_err_o <= 1'b1;
            end
          end
        end
        TX_REQ: begin
          if (tx_done) begin
            rtr_req_o <= 1'b0;
            tx_state  <= TX_WAIT_LOW;
          end
        end
        TX_WAIT_LOW: begin
          if (!rtr_ack_i) tx_state <= TX_IDLE;
        end
        default: begin
          rtr_req_o <= 1'b0;
          tx_state  <= TX_IDLE;
        end
      endcase
    end
  end

  // A flit is captured only from RX_IDLE, so each router request pushes exactly once.
  assign rx_push    = (rx_state == RX_IDLE) && rtr_req_i && !fifo_full;
  assign rx_valid_o = !fifo_empty;
  assign rx_pop     = rx_valid_o && rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state  <= RX_IDLE;
      rtr_ack_o <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_push) begin
            rtr_ack_o <= 1'b1;
            rx_state  <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!rtr_req_i) begin
            rtr_ack_o <= 1'b0;
            rx_state  <= RX_IDLE;
          end
        end
        default: begin
          rtr_ack_o <= 1'b0;
          rx_state  <= RX_IDLE;
        end
      endcase
    end
  end

  br_lite_ni_fifo #(
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (rx_push),
    .push_dat(rtr_flit_i),
    .pop     (rx_pop),
    .pop_dat (rx_data_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef BR_LITE_NI_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_cnt_o <= '0;
      rx_cnt_o <= '0;
    end else begin
      if (tx_done) tx_cnt_o <= tx_cnt_o + 32'd1;
      if (rx_push) rx_cnt_o <= rx_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_lite_ni.sv
// Scoreboard bench for br_lite_ni: TX flits and RX FIFO contents queued at stimulus, checked at DUT output.
`timescale 1ns/1ps
module tb_br_lite_ni;
  import br_lite_ni_pkg::*;

  localparam logic [15:0] ADDR  = 16'h0102;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_ni;
  logic                    tx_valid_i;
  logic                    tx_ready_o;
  logic [BR_ADDR_W-1:0]    tx_target_i;
  br_service_t             tx_service_i;
  logic [BR_PAYLOAD_W-1:0] tx_payload_i;
  logic                    tx_err_o;
  logic                    rx_valid_o;
  logic                    rx_ready_i;
  br_data_t                rx_data_o;
  br_data_t                rtr_flit_o;
  logic                    rtr_req_o;
  logic                    rtr_ack_i;
  logic                    rtr_busy_i;
  br_data_t                rtr_flit_i;
  logic                    rtr_req_i;
  logic                    rtr_ack_o;
`ifdef BR_LITE_NI_STATS_EN
  logic [31:0]             tx_cnt_o;
  logic [31:0]             rx_cnt_o;
`endif

  br_lite_ni #(.ADDRESS(ADDR), .RX_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .tx_valid_i  (tx_valid_i),
    .tx_ready_o  (tx_ready_o),
    .tx_target_i (tx_target_i),
    .tx_service_i(tx_service_i),
    .tx_payload_i(tx_payload_i),
    .tx_err_o    (tx_err_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .rx_data_o   (rx_data_o),
    .rtr_flit_o  (rtr_flit_o),
    .rtr_req_o   (rtr_req_o),
    .rtr_ack_i   (rtr_ack_i),
    .rtr_busy_i  (rtr_busy_i),
    .rtr_flit_i  (rtr_flit_i),
    .rtr_req_i   (rtr_req_i),
    .rtr_ack_o   (rtr_ack_o)
`ifdef BR_LITE_NI_STATS_EN
    ,
    .tx_cnt_o    (tx_cnt_o),
    .rx_cnt_o    (rx_cnt_o)
`endif
  );

  int                 n_vec = 0;
  int                 n_err = 0;
  br_data_t           tx_q[$];
  br_data_t           rx_q[$];
  logic [BR_ID_W-1:0] model_id;
  bit                 auto_rtr = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_ni     = 1'b0;
    tx_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    rtr_req_i  = 1'b0;
    rtr_ack_i  = 1'b0;
    rtr_busy_i = 1'b0;
    model_id   = '0;
    tx_q.delete();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  // Returns on the negedge just after the acceptance edge.
  task automatic send(input logic [1:0] svc, input logic [15:0] tgt, input logic [31:0] pl);
    int       n = 0;
    br_data_t f;
    while (!tx_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready_o) chk("tx_ready_timeout", tx_ready_o, 1);
    tx_valid_i   = 1'b1;
    tx_service_i = br_service_t'(svc);
    tx_target_i  = tgt;
    tx_payload_i = pl;
    if (svc == BR_SVC_ALL || svc == BR_SVC_TGT) begin
      f.src     = ADDR;
      f.tgt     = tgt;
      f.service = br_service_t'(svc);
      f.payload = pl;
      f.id      = model_id;
      model_id  = model_id + 1'b1;
      tx_q.push_back(f);
    end
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_tx_idle;
    int n = 0;
    while (!(tx_q.size() == 0 && tx_ready_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tx_idle_timeout", tx_ready_o, 1);
  endtask

  function automatic br_data_t rx_flit(input int i);
    br_data_t f;
    f.src     = 16'h0A00 + 16'(i);
    f.tgt     = ADDR;
    f.service = BR_SVC_TGT;
    f.payload = $urandom;
    f.id      = BR_ID_W'(i + 3);
    return f;
  endfunction

  task automatic rtr_drive(input br_data_t f);
    rtr_flit_i = f;
    rtr_req_i  = 1'b1;
    rx_q.push_back(f);
  endtask

  task automatic wait_ack(input int max_wait, output bit acked);
    int n = 0;
    while (!rtr_ack_o && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    acked = rtr_ack_o;
  endtask

  task automatic rtr_drop;
    int n = 0;
    rtr_req_i = 1'b0;
    while (rtr_ack_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ack_fall", rtr_ack_o, 0);
  endtask

  task automatic pop_one;
    br_data_t e;
    chk("rx_valid", rx_valid_o, 1);
    if (rx_q.size() == 0) begin
      chk("rx_q_underflow", rx_q.size(), 1);
    end else begin
      e = rx_q.pop_front();
      chk("rx_data", rx_data_o, e);
    end
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  // Router local-input model: acks 3 cycles after seeing req, releases once req falls.
  initial begin : rtr_model
    int n;
    forever begin
      @(negedge clk);
      if (auto_rtr && rst_ni && rtr_req_o && !rtr_ack_i) begin
        if (tx_q.size() == 0) chk("tx_q_nonempty", tx_q.size(), 1);
        else chk("tx_flit", rtr_flit_o, tx_q.pop_front());
        repeat (3) @(negedge clk);
        rtr_ack_i = 1'b1;
        n = 0;
        while (rtr_req_o && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("tx_req_fall", rtr_req_o, 0);
        rtr_ack_i = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    br_data_t e;
    bit       acked;
    bit       seen_rdy;
    int       acks;

    rst_ni       = 1'b0;
    tx_valid_i   = 1'b0;
    tx_target_i  = '0;
    tx_service_i = BR_SVC_ALL;
    tx_payload_i = '0;
    rx_ready_i   = 1'b0;
    rtr_ack_i    = 1'b0;
    rtr_busy_i   = 1'b0;
    rtr_flit_i   = '0;
    rtr_req_i    = 1'b0;
    model_id     = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_rtr_req", rtr_req_o, 0);
    chk("rst_rtr_ack", rtr_ack_o, 0);
    chk("rst_tx_err", tx_err_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rtr_flit", rtr_flit_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", tx_ready_o, 1);

    // Single broadcast, router driven by hand to check handshake timing.
    chk("t1_req_idle", rtr_req_o, 0);
    send(BR_SVC_ALL, 16'h0000, 32'h0000CAFE);
    e = tx_q.pop_front();
    chk("t1_req_rise", rtr_req_o, 1);
    chk("t1_flit", rtr_flit_o, e);
    chk("t1_id0", rtr_flit_o.id, 0);
    chk("t1_ready_low", tx_ready_o, 0);
    repeat (3) @(negedge clk);
    chk("t1_req_hold", rtr_req_o, 1);
    chk("t1_flit_stable", rtr_flit_o, e);
    rtr_ack_i = 1'b1;
    @(negedge clk);
    chk("t1_req_fall", rtr_req_o, 0);
    chk("t1_ready_wait_low", tx_ready_o, 0);
    rtr_ack_i = 1'b0;
    @(negedge clk);
    chk("t1_ready_back", tx_ready_o, 1);

    // Back-to-back targeted requests with router busy.
    do_reset();
    auto_rtr = 1'b1;
    send(BR_SVC_TGT, 16'h0304, 32'h11112222);
    rtr_busy_i = 1'b1;
    seen_rdy   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_ready_o) seen_rdy = 1'b1;
    end
    chk("t2_ready_during_busy", seen_rdy, 0);
    chk("t2_first_delivered", tx_q.size(), 0);
    rtr_busy_i = 1'b0;
    send(BR_SVC_TGT, 16'h0304, 32'h33334444);
    wait_tx_idle();
    chk("t2_second_id", rtr_flit_o.id, 1);

    // RX: five deliveries into a 4-deep FIFO, PE not popping.
    do_reset();
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      rtr_drive(rx_flit(i));
      wait_ack(10, acked);
      if (acked) acks++;
      rtr_drop();
    end
    chk("t3_acks", acks, 4);
    rtr_drive(rx_flit(4));
    wait_ack(10, acked);
    chk("t3_fifth_unacked", acked, 0);
    pop_one();
    wait_ack(10, acked);
    chk("t3_fifth_acked", acked, 1);
    rtr_drop();
    repeat (4) pop_one();
    chk("t3_empty", rx_valid_o, 0);
`ifdef BR_LITE_NI_STATS_EN
    chk("t3_rx_cnt", rx_cnt_o, 5);
`endif

    // Illegal services are dropped and do not consume an id.
    do_reset();
    send(BR_SVC_CLEAR, 16'h0304, 32'hDEAD0001);
    chk("t4_err_pulse", tx_err_o, 1);
    chk("t4_no_req", rtr_req_o, 0);
    @(negedge clk);
    chk("t4_err_single", tx_err_o, 0);
    chk("t4_no_req_later", rtr_req_o, 0);
    send(2'd3, 16'h0304, 32'hDEAD0002);
    chk("t4_err_svc3", tx_err_o, 1);
    send(BR_SVC_ALL, 16'h0000, 32'h00000042);
    wait_tx_idle();
    chk("t4_id0", rtr_flit_o.id, 0);

    // Reset in the middle of both handshakes.
    do_reset();
    auto_rtr = 1'b0;
    send(BR_SVC_ALL, 16'h0000, 32'h0BAD0BAD);
    rtr_flit_i = rx_flit(9);
    rtr_req_i  = 1'b1;
    wait_ack(10, acked);
    chk("t5_in_tx_req", rtr_req_o, 1);
    chk("t5_in_rx_ack", acked, 1);
    rst_ni = 1'b0;
    #1;
    chk("t5_req_drop", rtr_req_o, 0);
    chk("t5_ack_drop", rtr_ack_o, 0);
    chk("t5_fifo_empty", rx_valid_o, 0);
    rtr_req_i = 1'b0;
    tx_q.delete();
    model_id = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("t5_fifo_empty_after", rx_valid_o, 0);
    auto_rtr = 1'b1;
    send(BR_SVC_ALL, 16'h0000, 32'h00000077);
    wait_tx_idle();
    chk("t5_id0", rtr_flit_o.id, 0);

    // id wrap: 2^id_w + 1 requests.
    do_reset();
    for (int i = 0; i < (1 << BR_ID_W) + 1; i++) begin
      send(BR_SVC_ALL, 16'h0000, 32'(i));
    end
    wait_tx_idle();
    chk("t6_id_wrap", rtr_flit_o.id, 0);
`ifdef BR_LITE_NI_STATS_EN
    chk("t6_tx_cnt", tx_cnt_o, (1 << BR_ID_W) + 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/br_lite_ni.md
Name: br_lite_ni

Overview:
- Local-port network interface for a BrLite router; sits between a processing element (PE) and the router LOCAL port.
- TX path: accepts broadcast/target requests from the PE, builds full flits (source = ADDRESS, auto-incremented id) and injects them with the router's 4-phase req/ack handshake.
- TX honours the router's local-busy flag.
- RX path: captures flits the router delivers on LOCAL into a small FIFO, acknowledges them, and presents them to the PE through a valid/ready interface.

Parameters:
- ADDRESS, 16'h0000, this node's address; written into the flit source field.
- RX_DEPTH, 4, RX FIFO entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- tx_valid_i  in  1  PE request valid
- tx_ready_o  out  1  NI can accept a request
- tx_target_i  in  16  target address (used for BR_SVC_TGT)
- tx_service_i  in  br_service_t  BR_SVC_ALL or BR_SVC_TGT
- tx_payload_i  in  payload width  payload
- tx_err_o  out  1  one-cycle pulse: illegal service was dropped
- rx_valid_o  out  1  FIFO head valid
- rx_ready_i  in  1  PE pops the head
- rx_data_o  out  br_data_t  FIFO head
- rtr_flit_o  out  br_data_t  flit to the router local input
- rtr_req_o  out  1  request to the router local input
- rtr_ack_i  in  1  ack from the router local input
- rtr_busy_i  in  1  router local_busy (a local entry is still live)
- rtr_flit_i  in  br_data_t  flit from the router local output
- rtr_req_i  in  1  request from the router local output
- rtr_ack_o  out  1  ack to the router local output

Behaviour:
- Reset: reset rst_ni, asynchronous, active-low; clock clk_i.
  - Outputs cleared: tx_ready_o=0 while in reset, rtr_req_o=0, rtr_ack_o=0, tx_err_o=0, rx_valid_o=0, rtr_flit_o=0.
  - State cleared: id counter=0, FIFO empty, both FSMs in IDLE.
  - A reset mid-handshake drops req/ack immediately; the partially delivered flit is discarded.
- TX FSM states: TX_IDLE, TX_REQ, TX_WAIT_LOW.
  - tx_ready_o = (state==TX_IDLE) && !rtr_busy_i.
  - On tx_valid_i && tx_ready_o with service ALL or TGT:
    - latch flit {source=ADDRESS, target, service, payload, id=id_cnt};
    - id_cnt++ (wraps modulo 2^id width);
    - go to TX_REQ.
  - On tx_valid_i && tx_ready_o with service CLEAR or any other value: the request is consumed, tx_err_o pulses for 1 cycle, state stays TX_IDLE, id_cnt is unchanged.
  - TX_REQ: rtr_req_o=1, rtr_flit_o held stable; on rtr_ack_i=1 go to TX_WAIT_LOW.
  - TX_WAIT_LOW: rtr_req_o=0; on rtr_ack_i=0 go to TX_IDLE.
  - rtr_req_o is registered: it rises the cycle after acceptance.
  - The router may ignore a duplicate without raising busy; the NI does not distinguish this case.
- RX FSM states: RX_IDLE, RX_ACK.
  - RX_IDLE: if rtr_req_i && FIFO not full, push rtr_flit_i at that edge and go to RX_ACK.
  - RX_IDLE with FIFO full: hold, no ack. This backpressures the router, which stalls in its local-delivery state.
  - RX_ACK: rtr_ack_o=1 (registered, first high the cycle after the push); when rtr_req_i=0, go to RX_IDLE and rtr_ack_o falls.
  - No second push until the FSM returns to RX_IDLE.
  - A push and a pop in the same cycle on a full FIFO: the pop frees the slot next cycle only; the full flag uses registered state.
- FIFO: first-word-fall-through; rx_data_o is valid whenever rx_valid_o=1; read/write pointers wrap at RX_DEPTH with an extra MSB for the full/empty test.
- TX and RX are independent and may be active in the same cycle.

Optional Feature:
- BR_LITE_NI_STATS_EN defined:
  - adds outputs tx_cnt_o[31:0] (incremented on each TX_REQ->TX_WAIT_LOW) and rx_cnt_o[31:0] (incremented on each FIFO push);
  - both wrap, both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- BrLitePkg, shared: br_data_t, br_service_t, BR_SVC_* constants, id width; no new package entries.
- New in BrLitePkg: the tx_state_t and rx_state_t enums.
- Sub-module: br_lite_ni_fifo (parameter DEPTH, data type br_data_t, push/pop/full/empty), instantiated for RX.

Test Plan (ADDRESS=16'h0102):
- PE sends ALL, payload 32'hCAFE; router model acks 3 cycles after req. Required:
  - rtr_req_o rises 1 cycle after acceptance;
  - flit = {source 0102, service ALL, id 0};
  - req falls the cycle after ack;
  - tx_ready_o returns after ack falls.
- Two TGT requests to 16'h0304 back-to-back, rtr_busy_i held 1 for 20 cycles after the first write. Required: tx_ready_o=0 throughout busy; second flit carries id 1.
- Router delivers 5 flits with RX_DEPTH=4, PE not popping. Required: 4 acks, 5th req unacked; after one pop, the 5th is accepted; rx_data_o order is preserved.
- tx_service_i=BR_SVC_CLEAR. Required: tx_err_o pulses once, rtr_req_o stays 0, next valid request uses id 0.
- Assert rst_ni low while in TX_REQ and RX_ACK. Required: rtr_req_o=0, rtr_ack_o=0 in the same cycle, FIFO empty, id 0 after release.
- Inject 2^id-width + 1 requests. Required: the id wraps to 0 on the last; with BR_LITE_NI_STATS_EN, tx_cnt_o equals the request count.
